// File: rtl/param_bram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_bram_ctrl_pkg
//  Description : Shared state and mode encodings for the BRAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_bram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_WRITE   = 2'd0;
    localparam logic [1:0] MODE_READ    = 2'd1;
    localparam logic [1:0] MODE_WR_RD   = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/param_bram_ctrl_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_skid
//  Description : Two-entry FIFO holding BRAM read data for a valid/ready sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_skid #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DWIDTH-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop   = o_valid && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // The issuer guarantees a free slot for every push, so no full check here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_valid) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_valid) - 2'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : param_bram_ctrl
//  Description : Sequenced BRAM write/read engine with streamed read-back.
//                Optional o_checksum port enabled by macro CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_bram_ctrl
    import param_bram_ctrl_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [1:0]        i_mode,
    input  logic [AWIDTH-1:0] i_start_addr,
    input  logic [AWIDTH:0]   i_num_cnt,
    input  logic [DWIDTH-1:0] i_wdata_seed,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_read,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] q0,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_mem_data
`ifdef CHECKSUM_EN
    ,output logic [DWIDTH-1:0] o_checksum
`endif
);

    localparam logic [AWIDTH:0]   c_MEM_SIZE = (AWIDTH+1)'(MEM_SIZE);
    localparam logic [AWIDTH-1:0] c_LAST     = AWIDTH'(MEM_SIZE - 1);
    localparam logic [AWIDTH:0]   c_ONE      = (AWIDTH+1)'(1);

    state_t            r_state, w_next;
    logic [1:0]        r_mode;
    logic [AWIDTH-1:0] r_start, r_addr, w_addr_next;
    logic [AWIDTH:0]   r_num, r_idx, r_beats;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_rd_pend;
    logic              w_bad_cnt, w_last_wr, w_beat, w_rd_issue;
    logic [1:0]        w_skid_count;
    logic [2:0]        w_occ;

    assign w_bad_cnt   = (i_num_cnt == '0) || (i_num_cnt > c_MEM_SIZE);
    assign w_last_wr   = (r_idx == r_num - c_ONE);
    assign w_addr_next = (r_addr == c_LAST) ? '0 : r_addr + AWIDTH'(1);
    assign w_beat      = o_valid && i_ready;
    // Occupancy counts a beat leaving this cycle so back-to-back reads keep up.
    assign w_occ       = 3'(w_skid_count) + 3'(r_rd_pend) - 3'(w_beat);
    assign w_rd_issue  = (r_state == S_READ) && (r_idx < r_num) && (w_occ < 3'd2);

    assign o_idle  = (r_state == S_IDLE);
    assign o_write = (r_state == S_WRITE);
    assign o_read  = (r_state == S_READ);
    assign o_done  = (r_state == S_DONE);
    assign addr0   = r_addr;
    assign d0      = r_wdata;

    always_comb begin
        w_next = r_state;
        ce0    = 1'b0;
        we0    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    if (w_bad_cnt)                 w_next = S_DONE;
                    else if (i_mode == MODE_READ)  w_next = S_READ;
                    else                           w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                ce0 = 1'b1;
                we0 = 1'b1;
                if (w_last_wr) w_next = (r_mode == MODE_WRITE) ? S_DONE : S_READ;
            end
            S_READ: begin
                ce0 = w_rd_issue;
                if (w_beat && (r_beats == r_num - c_ONE)) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mode    <= MODE_WRITE;
            r_start   <= '0;
            r_addr    <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_beats   <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_rd_issue;
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_mode  <= i_mode;
                        r_start <= i_start_addr;
                        r_addr  <= i_start_addr;
                        r_num   <= i_num_cnt;
                        r_wdata <= i_wdata_seed;
                        r_idx   <= '0;
                        r_beats <= '0;
                    end
                end
                S_WRITE: begin
                    r_wdata <= r_wdata + DWIDTH'(1);
                    if (w_last_wr) begin
                        r_idx  <= '0;
                        r_addr <= r_start;
                    end else begin
                        r_idx  <= r_idx + c_ONE;
                        r_addr <= w_addr_next;
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_idx  <= r_idx + c_ONE;
                        r_addr <= w_addr_next;
                    end
                    if (w_beat) r_beats <= r_beats + c_ONE;
                end
                default: ;
            endcase
        end
    end

    bram_rd_skid #(
        .DWIDTH (DWIDTH)
    ) u_rd_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_rd_pend),
        .i_data  (q0),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_mem_data),
        .o_count (w_skid_count)
    );

`ifdef CHECKSUM_EN
    logic [DWIDTH-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (o_idle && i_run) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum + o_mem_data;
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_bram_ctrl
//  Description : Self-checking bench for param_bram_ctrl with a 1-cycle BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_bram_ctrl;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int MS = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_run;
    logic [1:0]    i_mode;
    logic [AW-1:0] i_start_addr;
    logic [AW:0]   i_num_cnt;
    logic [DW-1:0] i_wdata_seed;
    logic          o_idle, o_write, o_read, o_done;
    logic [AW-1:0] addr0;
    logic          ce0, we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_mem_data;
`ifdef CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_bram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_mode(i_mode),
        .i_start_addr(i_start_addr), .i_num_cnt(i_num_cnt), .i_wdata_seed(i_wdata_seed),
        .o_idle(o_idle), .o_write(o_write), .o_read(o_read), .o_done(o_done),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
        .o_valid(o_valid), .i_ready(i_ready), .o_mem_data(o_mem_data)
`ifdef CHECKSUM_EN
        , .o_checksum(o_checksum)
`endif
    );

    // BRAM model: one-cycle read latency
    logic [DW-1:0] bram [MS];
    logic [DW-1:0] ref_mem [MS];
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) bram[addr0] <= d0;
            q0 <= bram[addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampling on the falling edge
    int            cyc = 0, run_cyc = 0, done_cyc = 0;
    bit            done_seen, prev_done, prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] wa_q[$], ra_q[$];
    logic [DW-1:0] wd_q[$], bd_q[$];
    int            wc_q[$], bc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("flags_onehot", $countones({o_idle, o_write, o_read, o_done}), 1);
            if (o_idle || o_done) chk("no_access_idle_done", {ce0, we0}, 0);
            if (prev_done) chk("done_then_idle", {o_idle, o_done}, 2'b10);
            if (prev_stall) chk("stall_hold", {o_valid, o_mem_data}, {1'b1, prev_data});
            if (ce0 && we0) begin wa_q.push_back(addr0); wd_q.push_back(d0); wc_q.push_back(cyc); end
            if (ce0 && !we0) ra_q.push_back(addr0);
            if (o_valid && i_ready) begin bd_q.push_back(o_mem_data); bc_q.push_back(cyc); end
            if (o_idle && i_run) run_cyc = cyc;
            if (o_done) begin done_seen = 1'b1; done_cyc = cyc; end
            prev_done  = o_done;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_mem_data;
        end
    end

    function automatic logic pick(input int rk, input int k);
        case (rk)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return (k >= 4 && k < 9) ? 1'b0 : ((k % 2) == 0);
        endcase
    endfunction

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        ra_q.delete(); bd_q.delete(); bc_q.delete();
        done_seen = 1'b0;
    endtask

    task automatic do_run(input int mode, input int start, input int n, input int seed, input int rk);
        bit            bad;
        int            nw, nr, k;
        logic [DW-1:0] v;
        logic [DW-1:0] exp_beat[$];
        bad = (n == 0) || (n > MS);
        nw  = (!bad && mode != 1) ? n : 0;
        nr  = (!bad && mode != 0) ? n : 0;
        clear_mon();
        @(posedge clk); #1;
        i_mode = 2'(mode); i_start_addr = AW'(start); i_num_cnt = (AW+1)'(n);
        i_wdata_seed = DW'(seed); i_run = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        k = 0;
        while (!done_seen && k < 2000) begin
            i_ready = pick(rk, k);
            @(posedge clk); #1;
            k++;
        end
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("run_completes", {31'd0, done_seen}, 1);
        if (bad) chk("bad_cnt_done_next", done_cyc - run_cyc, 1);
        // reference: write seed+k to (start+k) mod MS, read back same sequence
        chk("write_count", wa_q.size(), nw);
        for (int i = 0; i < nw; i++) begin
            v = DW'(seed) + DW'(i);
            ref_mem[(start + i) % MS] = v;
            if (i < wa_q.size()) begin
                chk("write_addr", wa_q[i], (start + i) % MS);
                chk("write_data", wd_q[i], v);
            end
        end
        for (int i = 0; i < nr; i++) exp_beat.push_back(ref_mem[(start + i) % MS]);
        chk("read_count", ra_q.size(), nr);
        chk("beat_count", bd_q.size(), nr);
        for (int i = 0; i < nr; i++) begin
            if (i < ra_q.size()) chk("read_addr", ra_q[i], (start + i) % MS);
            if (i < bd_q.size()) chk("beat_data", bd_q[i], exp_beat[i]);
        end
        if (rk == 0 && nw > 1 && wc_q.size() == nw) chk("write_rate", wc_q[nw-1] - wc_q[0], nw - 1);
        if (rk == 0 && nr > 1 && bc_q.size() == nr) chk("read_rate", bc_q[nr-1] - bc_q[0], nr - 1);
`ifdef CHECKSUM_EN
        begin
            logic [DW-1:0] sum;
            sum = '0;
            for (int i = 0; i < nr; i++) sum = sum + exp_beat[i];
            chk("checksum", o_checksum, sum);
        end
`endif
    endtask

    initial begin
        int k;
        for (int i = 0; i < MS; i++) begin
            bram[i]    = DW'($urandom);
            ref_mem[i] = bram[i];
        end
        reset = 1'b1; i_run = 1'b0; i_mode = 2'd0; i_start_addr = '0;
        i_num_cnt = '0; i_wdata_seed = '0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_idle", {o_idle, o_write, o_read, o_done}, 4'b1000);
        chk("reset_bus", {o_valid, ce0, we0, addr0, d0}, 0);
        chk("reset_mem_data", o_mem_data, 0);
        reset = 1'b0;

        do_run(2, 0, 100, 16'h1000, 0);
        do_run(2, 120, 16, 16'h0a5a, 0);
        do_run(1, 120, 8, 0, 2);
        do_run(2, 0, 0, 16'h5555, 0);
        do_run(1, 3, 129, 16'h5555, 0);

        // reset during the tenth write of a 50-word run
        clear_mon();
        @(posedge clk); #1;
        i_mode = 2'd0; i_start_addr = AW'(30); i_num_cnt = (AW+1)'(50);
        i_wdata_seed = 16'h2222; i_run = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        k = 0;
        while (wa_q.size() < 10 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("reset_reach_write10", wa_q.size(), 10);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("midreset_idle", {o_idle, o_write, o_read, o_done}, 4'b1000);
        chk("midreset_no_access", {ce0, we0, o_valid}, 0);
        chk("midreset_addr_data", {addr0, d0}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) ref_mem[(30 + i) % MS] = 16'h2222 + DW'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_more_writes", wa_q.size(), 10);
        do_run(2, 30, 20, 16'h7777, 1);
        do_run(1, 30, 12, 0, 1);

        for (int r = 0; r < 6; r++)
            do_run($urandom_range(0, 3), $urandom_range(0, MS - 1), $urandom_range(1, 24),
                   $urandom, $urandom_range(0, 1));

        do_run(2, 64, 4, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
